// File: rtl/alu_hazard_ctrl.sv
// Hazard and forwarding controller around the ALU stage: tracks in-flight writes,
// stalls decode on load-use and produces registered operand-forwarding selects.
module alu_hazard_ctrl #(
  parameter int ADR_W = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dec_valid,
  input  logic [ADR_W-1:0] dec_regA_adr,
  input  logic [ADR_W-1:0] dec_regB_adr,
  input  logic             dec_useA,
  input  logic             dec_useB,
  input  logic             dec_we,
  input  logic [ADR_W-1:0] dec_destReg_adr,
  input  logic             dec_is_load,
  output logic             stall,
  output logic             bubble,
  output logic [1:0]       fwdA_sel,
  output logic [1:0]       fwdB_sel,
  output logic [1:0]       inflight_cnt,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef struct packed {
    logic             valid;
    logic [ADR_W-1:0] adr;
    logic             is_load;
  } entry_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_e;

  // Index 0 = ALU stage, 1 = MEM stage, 2 = WB stage.
  entry_t           sb_q [3];
  entry_t           e0_d;
  logic [2:0]       match_a;
  logic [2:0]       match_b;
  fwd_e             fwd_a_d, fwd_a_q;
  fwd_e             fwd_b_d, fwd_b_q;
  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      match_a[i] = dec_valid & dec_useA & sb_q[i].valid & (sb_q[i].adr == dec_regA_adr);
      match_b[i] = dec_valid & dec_useB & sb_q[i].valid & (sb_q[i].adr == dec_regB_adr);
    end
  end

  // Only a load sitting in the ALU stage is too late to bypass; one cycle later it
  // reaches MEM and the WB-stage bypass covers it.
  assign stall  = ~reset & (match_a[0] | match_b[0]) & sb_q[0].is_load;
  assign bubble = stall;

  function automatic fwd_e pick_fwd(input logic [2:0] match);
    // WB-stage producer needs no bypass: the register file writes before it reads.
    if (match[0])      return FWD_MEM;
    else if (match[1]) return FWD_WB;
    else               return FWD_RF;
  endfunction

  always_comb begin
    fwd_a_d = stall ? FWD_RF : pick_fwd(match_a);
    fwd_b_d = stall ? FWD_RF : pick_fwd(match_b);
    e0_d    = '{valid: dec_valid & dec_we & ~stall,
                adr: dec_destReg_adr,
                is_load: dec_is_load};
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  // NOTE: every register here uses <= so all stages shift from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) sb_q[i] <= '0;
      fwd_a_q     <= FWD_RF;
      fwd_b_q     <= FWD_RF;
      stall_cnt_q <= '0;
    end else begin
      sb_q[2]     <= sb_q[1];
      sb_q[1]     <= sb_q[0];
      sb_q[0]     <= e0_d;
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fwdA_sel     = fwd_a_q;
  assign fwdB_sel     = fwd_b_q;
  assign stall_cycles = stall_cnt_q;
  assign inflight_cnt = {1'b0, sb_q[0].valid} + {1'b0, sb_q[1].valid} + {1'b0, sb_q[2].valid};

endmodule

// File: doc/alu_hazard_ctrl.md
Name: alu_hazard_ctrl

Overview:
- Hazard and forwarding controller for the decode -> ALU -> MEM -> WB pipeline around the ALU stage.
- Keeps a scoreboard of in-flight register writes.
- Detects read-after-write (RAW) hazards for the instruction in decode.
- Stalls decode and inserts a bubble into the ALU stage register on load-use.
- Produces registered forwarding selects, aligned with the ALU stage register, for the regA and regB operand muxes.

Parameters:
- ADR_W, 3, register address width (8 architectural registers).
- CNT_W, 8, width of the saturating stall-cycle counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; clears all state.
- dec_valid  input  1  decode holds a valid instruction.
- dec_regA_adr  input  ADR_W  source A address.
- dec_regB_adr  input  ADR_W  source B address.
- dec_useA  input  1  instruction reads source A.
- dec_useB  input  1  instruction reads source B; 0 for immediate-form cop 0011.
- dec_we  input  1  instruction writes destination.
- dec_destReg_adr  input  ADR_W  destination address.
- dec_is_load  input  1  result produced at end of MEM, not ALU.
- stall  output  1  combinational; 1 = hold fetch/decode (their enable low).
- bubble  output  1  combinational; 1 = load NOP (we=0) into ALU stage register this edge.
- fwdA_sel  output  2  registered operand-A select in ALU stage: 00 regfile, 01 MEM-stage result, 10 WB-stage result, 11 reserved (never driven).
- fwdB_sel  output  2  same encoding for operand B.
- inflight_cnt  output  2  number of valid scoreboard entries (0..3).
- stall_cycles  output  CNT_W  saturating count of cycles with stall=1.

Behaviour:
- Scoreboard: 3 entries {valid, adr, is_load}.
  - E0 = instruction in ALU stage.
  - E1 = instruction in MEM stage.
  - E2 = instruction in WB stage.
- Every edge, not in reset:
  - E2 <= E1; E1 <= E0 (downstream never stalls).
  - E0 <= {dec_valid & dec_we & ~stall, dec_destReg_adr, dec_is_load}.
  - When stall=1, E0.valid <= 0 (bubble).
- Match A: dec_valid & dec_useA & Ex.valid & Ex.adr == dec_regA_adr. Match B is the same using source B.
- stall = dec_valid & ((useA & E0 match & E0.is_load) | (useB & E0 match & E0.is_load)). Load-use costs exactly 1 stall cycle.
- bubble = stall.
- stall is forced to 0 while reset=1.
- Forward select computed for the decode instruction, registered on the edge it issues (stall=0):
  - E0 match -> 01: producer will be in MEM next cycle.
  - else E1 match -> 10: producer will be in WB next cycle.
  - else 00.
  - E0 has priority over E1 (youngest producer wins).
  - E2 match -> 00: regfile is write-before-read in WB, no bypass needed.
- On stall=1 or dec_valid=0: fwdA_sel/fwdB_sel <= 00 (bubble carries no forwarding).
- Source unused (useX=0): fwdX_sel <= 00 regardless of match.
- An instruction whose dest equals its own source checks only older entries; its own write never forwards to itself.
- inflight_cnt = E0.valid + E1.valid + E2.valid, combinational from the scoreboard.
- stall_cycles increments each cycle stall=1, saturates at all-ones, never wraps.
- Reset (synchronous, any time, including mid-stall):
  - All entries invalid; fwdA_sel=fwdB_sel=00; stall_cycles=0; inflight_cnt=0.
  - stall=bubble=0 during reset and, with empty scoreboard, the cycle after.
  - Instructions pending in decode are re-evaluated after reset against the empty scoreboard.
- Latency:
  - stall/bubble: 0 cycles (same cycle as decode inputs).
  - fwd selects: 1 cycle (aligned with ALU stage register output).

Test Plan:
- Back-to-back dependency: cycle0 issue we=1 dest=3; cycle1 decode reads A=3 -> stall=0, next cycle fwdA_sel=01, fwdB_sel=00.
- Distance-2 dependency: dest=5 issue, unrelated issue, then read B=5 -> fwdB_sel=10. Distance 3 -> fwdB_sel=00, inflight_cnt=3.
- Load-use: load dest=2 then read A=2, B=2:
  - stall=bubble=1 for exactly 1 cycle; stall_cycles=1.
  - Next cycle stall=0; following cycle fwdA_sel=fwdB_sel=10.
- Priority: issue dest=4, then dest=4 again, then read A=4 -> fwdA_sel=01 (youngest).
- Immediate / no-write: dec_useB=0 with B matching E0 -> fwdB_sel=00. Producer with dec_we=0 -> no entry, inflight_cnt unchanged.
- Reset mid-stall:
  - Load dest=1 followed by read 1; assert reset during stall.
  - Same cycle stall=0; after reset inflight_cnt=0, stall_cycles=0, fwd selects 00.
  - Saturation: hold load-use pattern 300 stall cycles -> stall_cycles=255.
